// File: rtl/morse_player.sv
// Plays a 5-symbol Morse pattern (bit 4 first, 1 = dash, 0 = dot) on a tone output.
// Timing is expressed in units of UNIT_CYCLES clocks. All outputs are registered.
module morse_player #(
   parameter int UNIT_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [4:0] code,
   output logic       tone,
   output logic       busy,
   output logic       done,
   output logic [2:0] sym_idx
);

   // 3*UNIT_CYCLES is never a power of two, so this width always holds 3*UNIT_CYCLES-1
   localparam int CNT_W = $clog2(3 * UNIT_CYCLES);
   localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(3 * UNIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MARK,
      S_GAP,
      S_TAIL
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [4:0]       r_code, w_code_nxt;
   logic [2:0]       r_idx, w_idx_nxt;
   logic             r_tone, w_tone_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             w_mark_end;

   // The latched pattern shifts left per symbol, so bit 4 is always the current one
   assign w_mark_end = r_code[4] ? (r_cnt == DASH_LAST) : (r_cnt == DOT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_code  <= '0;
         r_idx   <= '0;
         r_tone  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_code  <= w_code_nxt;
         r_idx   <= w_idx_nxt;
         r_tone  <= w_tone_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_code_nxt  = r_code;
      w_idx_nxt   = r_idx;
      w_tone_nxt  = r_tone;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (start && !abort) begin
               w_state_nxt = S_MARK;
               w_code_nxt  = code;
               w_idx_nxt   = 3'd0;
               w_tone_nxt  = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
         S_MARK: begin
            if (w_mark_end) begin
               w_cnt_nxt   = '0;
               w_tone_nxt  = 1'b0;
               w_state_nxt = (r_idx == 3'd4) ? S_TAIL : S_GAP;
            end
         end
         S_GAP: begin
            if (r_cnt == DOT_LAST) begin
               w_state_nxt = S_MARK;
               w_cnt_nxt   = '0;
               w_idx_nxt   = r_idx + 3'd1;
               w_code_nxt  = {r_code[3:0], 1'b0};
               w_tone_nxt  = 1'b1;
            end
         end
         S_TAIL: begin
            if (r_cnt == DASH_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = 3'd0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Cancelling playback overrides whatever the active state decided
      if (abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_idx_nxt   = 3'd0;
         w_tone_nxt  = 1'b0;
         w_busy_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
      end
   end

   assign tone    = r_tone;
   assign busy    = r_busy;
   assign done    = r_done;
   assign sym_idx = r_idx;

endmodule
